bus_arbiter_rr: RTL



---
 rtl/bus_arbiter_rr.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: arbitrates N request ports onto one downstream bus.
// Fixed-priority (MODE 0) or round-robin (MODE 1) selection, one transfer
// at a time, optional timeout that completes a stalled transfer with o_err.
module bus_arbiter_rr #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MODE      = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_MASTERS-1:0]     i_bus_en,
    input  logic [N_MASTERS-1:0]     i_wr_rd,
    input  logic [N_MASTERS*DW-1:0]  i_wr_data,
    input  logic [N_MASTERS*AW-1:0]  i_addr,
    input  logic [N_MASTERS*3-1:0]   i_size,
    output logic [N_MASTERS-1:0]     o_ack,
    output logic [N_MASTERS-1:0]     o_err,
    output logic [DW-1:0]            o_rd_data,
    output logic [N_MASTERS-1:0]     o_grant,
    input  logic                     i_ack,
    input  logic [DW-1:0]            i_rd_data,
    output logic                     o_bus_en,
    output logic                     o_wr_rd,
    output logic [DW-1:0]            o_wr_data,
    output logic [AW-1:0]            o_addr,
    output logic [2:0]               o_size
);

    localparam int PW = $clog2(N_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] PTR_LAST = PW'(N_MASTERS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        wait_cnt_q, wait_cnt_d;

    logic                 busy;
    logic                 own_req;
    logic                 timeout_hit;
    logic [PW-1:0]        base_ptr;
    logic [N_MASTERS-1:0] rot_req;
    logic [N_MASTERS-1:0] rot_oh;
    logic [N_MASTERS-1:0] winner;
    logic                 found;
    logic [PW-1:0]        served_idx;
    logic [PW-1:0]        served_next;

    assign busy        = (state_q == BUSY);
    assign own_req     = |(i_bus_en & grant_q);
    assign timeout_hit = (TIMEOUT > 0) && busy && !i_ack && (wait_cnt_q == CNT_LAST);
    assign base_ptr    = (MODE == 0) ? '0 : rr_ptr_q;

    // Winner search: rotate requests so the search start sits at bit 0,
    // take the lowest set bit, then rotate the one-hot back into place.
    // Fixed priority is the same search with the start forced to 0.
    always_comb begin
        rot_req = N_MASTERS'({i_bus_en, i_bus_en} >> base_ptr);
        rot_oh  = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (!found && rot_req[k]) begin
                rot_oh[k] = 1'b1;
                found     = 1'b1;
            end
        end
        winner = N_MASTERS'(({rot_oh, rot_oh} << base_ptr) >> N_MASTERS);
    end

    // Index of the current owner and the round-robin pointer that follows it
    always_comb begin
        served_idx = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (grant_q[k]) begin
                served_idx = PW'(k);
            end
        end
        served_next = (served_idx == PTR_LAST) ? '0 : served_idx + 1'b1;
    end

    // Next-state logic: grant in IDLE, complete on ack, timeout or abort
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (|i_bus_en) begin
                    state_d    = BUSY;
                    grant_d    = winner;
                    wait_cnt_d = '0;
                end
            end
            BUSY: begin
                if (i_ack || timeout_hit || !own_req) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = served_next;
                end else if ((TIMEOUT > 0) && (wait_cnt_q != '1)) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Downstream request mux: live inputs of the owner, zero when idle
    always_comb begin
        o_wr_rd   = 1'b0;
        o_wr_data = '0;
        o_addr    = '0;
        o_size    = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (busy && grant_q[k]) begin
                o_wr_rd   = i_wr_rd[k];
                o_wr_data = i_wr_data[k*DW +: DW];
                o_addr    = i_addr[k*AW +: AW];
                o_size    = i_size[k*3 +: 3];
            end
        end
    end

    assign o_bus_en  = busy;
    assign o_grant   = grant_q;
    assign o_ack     = busy ? (grant_q & {N_MASTERS{i_ack}}) : '0;
    assign o_err     = timeout_hit ? grant_q : '0;
    assign o_rd_data = i_rd_data;

endmodule
